// File: rtl/jstk_spi_master.sv
// PmodJSTK SPI master: one 5-byte mode-0 transaction per accepted start, result in in_bytes.
// Build option JSTK_DECODE_EN adds registered x_pos/y_pos/btn fields decoded from the result.
module jstk_spi_master #(
    parameter int CLK_DIV      = 50,
    parameter int SS_SETUP_CYC = 1500,
    parameter int BYTE_GAP_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  led_cmd,
    input  logic        miso,
    output logic        ss,
    output logic        sclk,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic [39:0] in_bytes
`ifdef JSTK_DECODE_EN
    ,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [2:0]  btn
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_e;

    localparam int CNT_MAX0 = (SS_SETUP_CYC > BYTE_GAP_CYC) ? SS_SETUP_CYC : BYTE_GAP_CYC;
    localparam int CNT_MAX  = (CNT_MAX0 > 2 * CLK_DIV) ? CNT_MAX0 : 2 * CLK_DIV;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       LAST_BYTE  = 3'd4;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [1:0]        led_q, led_d;
    logic [39:0]       shift_q, shift_d;
    logic [7:0]        tx_byte;

    logic              ss_q, ss_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [39:0]       in_bytes_q, in_bytes_d;
`ifdef JSTK_DECODE_EN
    logic [9:0]        x_pos_q, x_pos_d;
    logic [9:0]        y_pos_q, y_pos_d;
    logic [2:0]        btn_q, btn_d;
`endif

    // Pins are registered from the current state, so they trail the FSM by one clock;
    // miso is captured on the very edge that raises the sclk pin.
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        led_d      = led_q;
        shift_d    = shift_q;
        ss_d       = 1'b1;
        sclk_d     = 1'b0;
        mosi_d     = 1'b0;
        busy_d     = (state_q != S_IDLE);
        done_d     = 1'b0;
        in_bytes_d = in_bytes_q;
`ifdef JSTK_DECODE_EN
        x_pos_d    = x_pos_q;
        y_pos_d    = y_pos_q;
        btn_d      = btn_q;
`endif
        tx_byte    = (byte_idx_q == 3'd0) ? {6'b100000, led_q} : 8'h00;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SETUP;
                    led_d      = led_cmd;
                    cnt_d      = '0;
                    byte_idx_d = 3'd0;
                    bit_idx_d  = 3'd7;
                    shift_d    = '0;
                end
            end

            S_SETUP: begin
                ss_d   = 1'b0;
                mosi_d = tx_byte[bit_idx_q];
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_SHIFT: begin
                ss_d   = 1'b0;
                mosi_d = tx_byte[bit_idx_q];
                sclk_d = (cnt_q >= HALF);
                if (cnt_q == HALF) begin
                    shift_d = {shift_q[38:0], miso};
                end
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd0) begin
                        bit_idx_d = 3'd7;
                        if (byte_idx_q == LAST_BYTE) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_GAP;
                            byte_idx_d = byte_idx_q + 3'd1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q - 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_GAP: begin
                ss_d   = 1'b0;
                mosi_d = tx_byte[bit_idx_q];
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE: begin
                done_d     = 1'b1;
                in_bytes_d = shift_q;
`ifdef JSTK_DECODE_EN
                x_pos_d    = {shift_q[25:24], shift_q[39:32]};
                y_pos_d    = {shift_q[9:8], shift_q[23:16]};
                btn_d      = shift_q[2:0];
`endif
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd7;
            byte_idx_q <= 3'd0;
            led_q      <= 2'b00;
            shift_q    <= '0;
            ss_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_bytes_q <= '0;
`ifdef JSTK_DECODE_EN
            x_pos_q    <= '0;
            y_pos_q    <= '0;
            btn_q      <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            led_q      <= led_d;
            shift_q    <= shift_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_bytes_q <= in_bytes_d;
`ifdef JSTK_DECODE_EN
            x_pos_q    <= x_pos_d;
            y_pos_q    <= y_pos_d;
            btn_q      <= btn_d;
`endif
        end
    end

    assign ss       = ss_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign in_bytes = in_bytes_q;
`ifdef JSTK_DECODE_EN
    assign x_pos    = x_pos_q;
    assign y_pos    = y_pos_q;
    assign btn      = btn_q;
`endif

endmodule
